// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if
//   Control, event and read-back bundle for the performance counter bank.
//   Parameters NUM_CH / WIDTH must match the attached perf_counter_bank.
// Signals
//   start, stop, halt, clear, snap   run-control and snapshot strobes
//   ev_in   [NUM_CH]                 per-channel event strobes
//   rd_sel  [SEL_W]                  channel to read
//   rd_data [WIDTH]                  registered read data
//   ovf     [NUM_CH]                 sticky overflow flags
//   running                          1 while the bank is counting
// Modports
//   master  drives controls/events, observes read-back (core / bench side)
//   slave   the counter bank itself
interface perf_counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              start;
    logic              stop;
    logic              halt;
    logic              clear;
    logic              snap;
    logic [NUM_CH-1:0] ev_in;
    logic [SEL_W-1:0]  rd_sel;
    logic [WIDTH-1:0]  rd_data;
    logic [NUM_CH-1:0] ovf;
    logic              running;

    modport master (
        output start, stop, halt, clear, snap, ev_in, rd_sel,
        input  rd_data, ovf, running
    );

    modport slave (
        input  start, stop, halt, clear, snap, ev_in, rd_sel,
        output rd_data, ovf, running
    );
endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Bank of NUM_CH performance counters gated by a global run FSM
//   (IDLE / RUNNING / HALTED). Channel 0 can count cycles instead of events.
//   Each channel has a sticky overflow flag; read-back is a registered mux.
// Configuration macro
//   PERF_CNT_SNAPSHOT_EN  when defined, a snapshot bank is added, 'snap'
//                         copies all live counters atomically and rd_data
//                         reads the snapshot bank. Undefined: snap is ignored
//                         and rd_data reads the live counters.
// Ports
//   clk    system clock (posedge)
//   rst_n  asynchronous active-low reset
//   bus    perf_counter_bank_if.slave (controls, events, read-back, flags)
module perf_counter_bank #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int CYCLE_CH0  = 1,
    parameter int SATURATE   = 0,
    parameter int AUTO_START = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    perf_counter_bank_if.slave bus
);
    localparam logic AUTO_BIT = (AUTO_START != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_HALTED  = 2'b10
    } state_t;

    state_t            state_reg;
    logic              running_reg;
    logic              auto_pending_reg;
    logic              stop_any;
    logic              count_en;
    logic [WIDTH-1:0]  rd_data_reg;
    logic [NUM_CH-1:0] ovf_w;
    logic [WIDTH-1:0]  src [NUM_CH];

    assign stop_any = bus.stop | bus.halt;
    // Counting needs RUNNING in the current cycle and no control action in it;
    // this also excludes the start cycle, since state is not yet RUNNING.
    assign count_en = (state_reg == ST_RUNNING) && !bus.clear && !stop_any;

    // Run FSM. auto_pending_reg is set only by reset, so auto-start fires on
    // the first edge after release and never again after a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            running_reg      <= 1'b0;
            auto_pending_reg <= AUTO_BIT;
        end else begin
            auto_pending_reg <= 1'b0;
            if (bus.clear) begin
                state_reg   <= ST_IDLE;
                running_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!stop_any && (bus.start || auto_pending_reg)) begin
                            state_reg   <= ST_RUNNING;
                            running_reg <= 1'b1;
                        end
                    end
                    ST_RUNNING: begin
                        if (stop_any) begin
                            state_reg   <= ST_HALTED;
                            running_reg <= 1'b0;
                        end
                    end
                    ST_HALTED: begin
                        // halt held high blocks restart; stop wins over start
                        if (!stop_any && bus.start) begin
                            state_reg   <= ST_RUNNING;
                            running_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        running_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] cnt_reg;
            logic             ovf_reg;
            logic             inc;

            if (gi == 0 && CYCLE_CH0 != 0) begin : g_cyc
                logic ev0_unused;
                assign ev0_unused = bus.ev_in[0];
                assign inc = count_en;
            end else begin : g_ev
                assign inc = count_en & bus.ev_in[gi];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (bus.clear) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (inc) begin
                    if (&cnt_reg) begin
                        ovf_reg <= 1'b1;
                        if (SATURATE == 0) begin
                            cnt_reg <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

`ifdef PERF_CNT_SNAPSHOT_EN
            // Non-blocking capture: snap with clear or increment in the same
            // cycle takes the value before that edge.
            logic [WIDTH-1:0] snap_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    snap_reg <= '0;
                end else if (bus.snap) begin
                    snap_reg <= cnt_reg;
                end
            end
            assign src[gi] = snap_reg;
`else
            assign src[gi] = cnt_reg;
`endif
            assign ovf_w[gi] = ovf_reg;
        end
    endgenerate

`ifndef PERF_CNT_SNAPSHOT_EN
    logic snap_unused;
    assign snap_unused = bus.snap;
`endif

    // Registered read mux; selects beyond the last channel read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (32'(bus.rd_sel) < NUM_CH) begin
            rd_data_reg <= src[bus.rd_sel];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign bus.rd_data = rd_data_reg;
    assign bus.ovf     = ovf_w;
    assign bus.running = running_reg;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank
//   Three banks in different configurations share clk/rst_n:
//     dut_a  4 ch, 32 bit, ch0 = cycles, wrap,     auto-start
//     dut_b  4 ch,  8 bit, ch0 = events, wrap,     manual start
//     dut_c  3 ch,  8 bit, ch0 = events, saturate, manual start
//   Expected read data is queued when the read is set up and popped when the
//   registered result appears one edge later. Inputs change and outputs are
//   sampled 1 time unit after each rising edge.
module tb_perf_counter_bank;
`ifdef PERF_CNT_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(32)) a_if ();
    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(8))  b_if ();
    perf_counter_bank_if #(.NUM_CH(3), .WIDTH(8))  c_if ();

    perf_counter_bank #(.NUM_CH(4), .WIDTH(32), .CYCLE_CH0(1), .SATURATE(0), .AUTO_START(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    perf_counter_bank #(.NUM_CH(4), .WIDTH(8), .CYCLE_CH0(0), .SATURATE(0), .AUTO_START(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    perf_counter_bank #(.NUM_CH(3), .WIDTH(8), .CYCLE_CH0(0), .SATURATE(1), .AUTO_START(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp_v;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic init_inputs();
        a_if.start = 0; a_if.stop = 0; a_if.halt = 0; a_if.clear = 0; a_if.snap = 0; a_if.ev_in = '0; a_if.rd_sel = '0;
        b_if.start = 0; b_if.stop = 0; b_if.halt = 0; b_if.clear = 0; b_if.snap = 0; b_if.ev_in = '0; b_if.rd_sel = '0;
        c_if.start = 0; c_if.stop = 0; c_if.halt = 0; c_if.clear = 0; c_if.snap = 0; c_if.ev_in = '0; c_if.rd_sel = '0;
    endtask

    // Reset values, then auto-start with ch0 counting cycles.
    task automatic test_reset();
        n_vec++; if (a_if.rd_data !== 32'd0) begin n_err++; $display("FAIL reset_a_rd_data: got %0d want 0", a_if.rd_data); end else $display("ok   reset_a_rd_data = %0d", a_if.rd_data);
        n_vec++; if (a_if.ovf !== 4'b0000) begin n_err++; $display("FAIL reset_a_ovf: got %b want 0000", a_if.ovf); end else $display("ok   reset_a_ovf = %b", a_if.ovf);
        n_vec++; if (a_if.running !== 1'b0) begin n_err++; $display("FAIL reset_a_running: got %b want 0", a_if.running); end else $display("ok   reset_a_running = %b", a_if.running);
        n_vec++; if (b_if.running !== 1'b0) begin n_err++; $display("FAIL reset_b_running: got %b want 0", b_if.running); end else $display("ok   reset_b_running = %b", b_if.running);
        rst_n = 1'b1;
        // edge 1 enters RUNNING, edges 2..10 count (ch0=9), edge 11 registers it
        a_if.rd_sel = 2'd0;
        exp_q.push_back(SNAP_EN ? 64'd0 : 64'd9);
        tick(11);
        exp_v = exp_q.pop_front();
        n_vec++; if (a_if.rd_data !== exp_v[31:0]) begin n_err++; $display("FAIL auto_ch0: got %0d want %0d", a_if.rd_data, exp_v[31:0]); end else $display("ok   auto_ch0 = %0d", a_if.rd_data);
        n_vec++; if (a_if.running !== 1'b1) begin n_err++; $display("FAIL auto_running: got %b want 1", a_if.running); end else $display("ok   auto_running = %b", a_if.running);
        n_vec++; if (b_if.running !== 1'b0) begin n_err++; $display("FAIL manual_b_idle: got %b want 0", b_if.running); end else $display("ok   manual_b_idle = %b", b_if.running);
        n_vec++; if (c_if.running !== 1'b0) begin n_err++; $display("FAIL manual_c_idle: got %b want 0", c_if.running); end else $display("ok   manual_c_idle = %b", c_if.running);
    endtask

    // start / stop / halt on dut_b with ev_in[1] held high.
    task automatic test_start_stop();
        b_if.ev_in = 4'b0010;
        b_if.start = 1; tick(1); b_if.start = 0;   // start cycle: not counted
        tick(5);                                   // 5 counted cycles
        b_if.stop = 1; tick(1); b_if.stop = 0;     // stop cycle: not counted
        tick(3);
        n_vec++; if (b_if.running !== 1'b0) begin n_err++; $display("FAIL stop_running: got %b want 0", b_if.running); end else $display("ok   stop_running = %b", b_if.running);
        b_if.rd_sel = 2'd1; b_if.snap = 1; tick(1); b_if.snap = 0;
        exp_q.push_back(64'd5);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (b_if.rd_data !== exp_v[7:0]) begin n_err++; $display("FAIL stop_ch1: got %0d want %0d", b_if.rd_data, exp_v[7:0]); end else $display("ok   stop_ch1 = %0d", b_if.rd_data);
        b_if.rd_sel = 2'd0;
        exp_q.push_back(64'd0);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (b_if.rd_data !== exp_v[7:0]) begin n_err++; $display("FAIL event_ch0_idle: got %0d want %0d", b_if.rd_data, exp_v[7:0]); end else $display("ok   event_ch0_idle = %0d", b_if.rd_data);
        b_if.halt = 1; b_if.start = 1; tick(1);
        n_vec++; if (b_if.running !== 1'b0) begin n_err++; $display("FAIL start_during_halt: got %b want 0", b_if.running); end else $display("ok   start_during_halt = %b", b_if.running);
        b_if.halt = 0; tick(1); b_if.start = 0;    // restart edge: not counted
        n_vec++; if (b_if.running !== 1'b1) begin n_err++; $display("FAIL restart_running: got %b want 1", b_if.running); end else $display("ok   restart_running = %b", b_if.running);
        tick(2);                                   // ch1 = 7
        b_if.halt = 1; tick(1); b_if.halt = 0;     // halt cycle: not counted
        n_vec++; if (b_if.running !== 1'b0) begin n_err++; $display("FAIL halt_running: got %b want 0", b_if.running); end else $display("ok   halt_running = %b", b_if.running);
        b_if.ev_in = '0;
        b_if.rd_sel = 2'd1; b_if.snap = 1; tick(1); b_if.snap = 0;
        exp_q.push_back(64'd7);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (b_if.rd_data !== exp_v[7:0]) begin n_err++; $display("FAIL halt_ch1: got %0d want %0d", b_if.rd_data, exp_v[7:0]); end else $display("ok   halt_ch1 = %0d", b_if.rd_data);
    endtask

    // 8-bit ch2: wrap on dut_b, saturate on dut_c.
    task automatic test_overflow();
        b_if.clear = 1; c_if.clear = 1; tick(1); b_if.clear = 0; c_if.clear = 0;
        b_if.start = 1; c_if.start = 1; tick(1); b_if.start = 0; c_if.start = 0;
        b_if.ev_in = 4'b0100; c_if.ev_in = 3'b100;
        tick(255);
        n_vec++; if (b_if.ovf !== 4'b0000) begin n_err++; $display("FAIL at_max_b_ovf: got %b want 0000", b_if.ovf); end else $display("ok   at_max_b_ovf = %b", b_if.ovf);
        n_vec++; if (c_if.ovf !== 3'b000) begin n_err++; $display("FAIL at_max_c_ovf: got %b want 000", c_if.ovf); end else $display("ok   at_max_c_ovf = %b", c_if.ovf);
        tick(1);
        b_if.ev_in = '0; c_if.ev_in = '0;
        n_vec++; if (b_if.ovf !== 4'b0100) begin n_err++; $display("FAIL wrap_b_ovf: got %b want 0100", b_if.ovf); end else $display("ok   wrap_b_ovf = %b", b_if.ovf);
        n_vec++; if (c_if.ovf !== 3'b100) begin n_err++; $display("FAIL sat_c_ovf: got %b want 100", c_if.ovf); end else $display("ok   sat_c_ovf = %b", c_if.ovf);
        b_if.rd_sel = 2'd2; c_if.rd_sel = 2'd2; b_if.snap = 1; c_if.snap = 1; tick(1); b_if.snap = 0; c_if.snap = 0;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd255);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (b_if.rd_data !== exp_v[7:0]) begin n_err++; $display("FAIL wrap_b_ch2: got %0d want %0d", b_if.rd_data, exp_v[7:0]); end else $display("ok   wrap_b_ch2 = %0d", b_if.rd_data);
        exp_v = exp_q.pop_front();
        n_vec++; if (c_if.rd_data !== exp_v[7:0]) begin n_err++; $display("FAIL sat_c_ch2: got %0d want %0d", c_if.rd_data, exp_v[7:0]); end else $display("ok   sat_c_ch2 = %0d", c_if.rd_data);
        c_if.ev_in = 3'b100; tick(1); c_if.ev_in = '0;
        c_if.snap = 1; tick(1); c_if.snap = 0;
        exp_q.push_back(64'd255);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (c_if.rd_data !== exp_v[7:0]) begin n_err++; $display("FAIL sat_c_hold: got %0d want %0d", c_if.rd_data, exp_v[7:0]); end else $display("ok   sat_c_hold = %0d", c_if.rd_data);
        c_if.rd_sel = 2'd3;
        exp_q.push_back(64'd0);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (c_if.rd_data !== exp_v[7:0]) begin n_err++; $display("FAIL sel_out_of_range: got %0d want %0d", c_if.rd_data, exp_v[7:0]); end else $display("ok   sel_out_of_range = %0d", c_if.rd_data);
        b_if.ev_in = 4'b0100; tick(3); b_if.ev_in = '0;
        n_vec++; if (b_if.ovf !== 4'b0100) begin n_err++; $display("FAIL ovf_sticky: got %b want 0100", b_if.ovf); end else $display("ok   ovf_sticky = %b", b_if.ovf);
    endtask

    // clear and start together while RUNNING: clear wins.
    task automatic test_clear_start();
        a_if.clear = 1; a_if.start = 1; c_if.clear = 1; c_if.start = 1;
        tick(1);
        a_if.clear = 0; a_if.start = 0; c_if.clear = 0; c_if.start = 0;
        n_vec++; if (a_if.running !== 1'b0) begin n_err++; $display("FAIL clear_a_running: got %b want 0", a_if.running); end else $display("ok   clear_a_running = %b", a_if.running);
        n_vec++; if (c_if.running !== 1'b0) begin n_err++; $display("FAIL clear_c_running: got %b want 0", c_if.running); end else $display("ok   clear_c_running = %b", c_if.running);
        n_vec++; if (c_if.ovf !== 3'b000) begin n_err++; $display("FAIL clear_c_ovf: got %b want 000", c_if.ovf); end else $display("ok   clear_c_ovf = %b", c_if.ovf);
        a_if.rd_sel = 2'd0; a_if.snap = 1; tick(1); a_if.snap = 0;
        exp_q.push_back(64'd0);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (a_if.rd_data !== exp_v[31:0]) begin n_err++; $display("FAIL clear_a_ch0: got %0d want %0d", a_if.rd_data, exp_v[31:0]); end else $display("ok   clear_a_ch0 = %0d", a_if.rd_data);
        tick(3);
        n_vec++; if (a_if.running !== 1'b0) begin n_err++; $display("FAIL clear_no_autostart: got %b want 0", a_if.running); end else $display("ok   clear_no_autostart = %b", a_if.running);
    endtask

    // ch0 reaches 100, snap, 20 more cycles; then snap+clear together.
    task automatic test_snapshot();
        a_if.rd_sel = 2'd0;
        a_if.start = 1; tick(1); a_if.start = 0;
        tick(100);                                 // ch0 = 100
        a_if.snap = 1; tick(1); a_if.snap = 0;     // snapshot 100, ch0 = 101
        tick(19);                                  // ch0 = 120
        exp_q.push_back(SNAP_EN ? 64'd100 : 64'd120);
        tick(1);                                   // ch0 = 121
        exp_v = exp_q.pop_front();
        n_vec++; if (a_if.rd_data !== exp_v[31:0]) begin n_err++; $display("FAIL snap_ch0: got %0d want %0d", a_if.rd_data, exp_v[31:0]); end else $display("ok   snap_ch0 = %0d", a_if.rd_data);
        a_if.snap = 1; a_if.clear = 1; tick(1); a_if.snap = 0; a_if.clear = 0;
        exp_q.push_back(SNAP_EN ? 64'd121 : 64'd0);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (a_if.rd_data !== exp_v[31:0]) begin n_err++; $display("FAIL snap_with_clear: got %0d want %0d", a_if.rd_data, exp_v[31:0]); end else $display("ok   snap_with_clear = %0d", a_if.rd_data);
    endtask

    // Asynchronous reset mid-run, then auto-restart on dut_a.
    task automatic test_async_reset();
        a_if.start = 1; tick(1); a_if.start = 0;
        tick(5);
        rst_n = 1'b0;
        #1;
        n_vec++; if (a_if.rd_data !== 32'd0) begin n_err++; $display("FAIL async_a_rd_data: got %0d want 0", a_if.rd_data); end else $display("ok   async_a_rd_data = %0d", a_if.rd_data);
        n_vec++; if (a_if.running !== 1'b0) begin n_err++; $display("FAIL async_a_running: got %b want 0", a_if.running); end else $display("ok   async_a_running = %b", a_if.running);
        n_vec++; if (b_if.ovf !== 4'b0000) begin n_err++; $display("FAIL async_b_ovf: got %b want 0000", b_if.ovf); end else $display("ok   async_b_ovf = %b", b_if.ovf);
        n_vec++; if (b_if.running !== 1'b0) begin n_err++; $display("FAIL async_b_running: got %b want 0", b_if.running); end else $display("ok   async_b_running = %b", b_if.running);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        n_vec++; if (a_if.running !== 1'b1) begin n_err++; $display("FAIL rerun_running: got %b want 1", a_if.running); end else $display("ok   rerun_running = %b", a_if.running);
        tick(4);                                   // ch0 = 4
        a_if.snap = 1; tick(1); a_if.snap = 0;     // snapshot 4, ch0 = 5
        exp_q.push_back(SNAP_EN ? 64'd4 : 64'd5);
        tick(1);
        exp_v = exp_q.pop_front();
        n_vec++; if (a_if.rd_data !== exp_v[31:0]) begin n_err++; $display("FAIL rerun_ch0: got %0d want %0d", a_if.rd_data, exp_v[31:0]); end else $display("ok   rerun_ch0 = %0d", a_if.rd_data);
        n_vec++; if (b_if.running !== 1'b0) begin n_err++; $display("FAIL rerun_b_idle: got %b want 0", b_if.running); end else $display("ok   rerun_b_idle = %b", b_if.running);
    endtask

    initial begin
        init_inputs();
        tick(3);
        test_reset();
        test_start_stop();
        test_overflow();
        test_clear_start();
        test_snapshot();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
